// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Time-shares one pipelined multiplier between the I and Q channel datapaths.
//   A round-robin arbiter picks one eligible requester per enabled cycle and
//   registers its operands onto the multiplier inputs. A channel tag travels
//   alongside the multiplier pipeline, so each product is steered back to the
//   channel that issued it, together with a one-cycle valid pulse.
//
// Ports
//   Clock, Reset        : rising-edge clock, synchronous active-high reset
//   Enable              : global clock enable; low freezes the block and multiplier
//   ReqI/AI/BI, AckI    : I channel request + operands, issue acknowledge pulse
//   ReqQ/AQ/BQ, AckQ    : Q channel request + operands, issue acknowledge pulse
//   MulClkEn            : multiplier ClkEn (follows Enable combinationally)
//   MulDataA/MulDataB   : registered multiplier operands
//   MulResult           : multiplier product, LATENCY enabled cycles after operands
//   ResultI/ValidI      : I product register and its one-cycle valid pulse
//   ResultQ/ValidQ      : Q product register and its one-cycle valid pulse
module mult_share_arbiter #(
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned LATENCY = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Enable,
  input  logic               ReqI,
  input  logic [WIDTH-1:0]   AI,
  input  logic [WIDTH-1:0]   BI,
  output logic               AckI,
  input  logic               ReqQ,
  input  logic [WIDTH-1:0]   AQ,
  input  logic [WIDTH-1:0]   BQ,
  output logic               AckQ,
  output logic               MulClkEn,
  output logic [WIDTH-1:0]   MulDataA,
  output logic [WIDTH-1:0]   MulDataB,
  input  logic [2*WIDTH-1:0] MulResult,
  output logic [2*WIDTH-1:0] ResultI,
  output logic               ValidI,
  output logic [2*WIDTH-1:0] ResultQ,
  output logic               ValidQ
);

  // One tag stage for the operand register plus LATENCY stages for the
  // multiplier itself; the last stage lines up with MulResult.
  localparam int unsigned Depth = LATENCY + 1;

  logic               ack_i_q, ack_q_q;
  logic               prio_q_q;  // 0: I wins a contested cycle, 1: Q wins
  logic [WIDTH-1:0]   data_a_q, data_b_q;
  logic [Depth-1:0]   tag_vld_q;
  logic [Depth-1:0]   tag_ch_q;  // 0: I, 1: Q
  logic [2*WIDTH-1:0] res_i_q, res_q_q;
  logic               valid_i_q, valid_q_q;

  logic elig_i, elig_q, contested, grant_i, grant_q;
  logic out_vld, out_ch;

  // A channel acked this cycle is not eligible, which bounds each channel to
  // one issue per two cycles and makes the pair alternate under contention.
  always_comb begin
    elig_i    = ReqI & ~ack_i_q;
    elig_q    = ReqQ & ~ack_q_q;
    contested = elig_i & elig_q;
    grant_i   = elig_i & (~elig_q | ~prio_q_q);
    grant_q   = elig_q & ~grant_i;
    out_vld   = tag_vld_q[Depth-1];
    out_ch    = tag_ch_q[Depth-1];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ack_i_q   <= 1'b0;
      ack_q_q   <= 1'b0;
      prio_q_q  <= 1'b0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      tag_vld_q <= '0;
      tag_ch_q  <= '0;
      res_i_q   <= '0;
      res_q_q   <= '0;
      valid_i_q <= 1'b0;
      valid_q_q <= 1'b0;
    end else if (Enable) begin
      ack_i_q <= grant_i;
      ack_q_q <= grant_q;
      if (contested) begin
        prio_q_q <= ~prio_q_q;
      end
      if (grant_i) begin
        data_a_q <= AI;
        data_b_q <= BI;
      end else if (grant_q) begin
        data_a_q <= AQ;
        data_b_q <= BQ;
      end
      // A cycle without a grant pushes a bubble.
      tag_vld_q <= {tag_vld_q[Depth-2:0], grant_i | grant_q};
      tag_ch_q  <= {tag_ch_q[Depth-2:0], grant_q};
      valid_i_q <= out_vld & ~out_ch;
      valid_q_q <= out_vld & out_ch;
      if (out_vld && !out_ch) begin
        res_i_q <= MulResult;
      end
      if (out_vld && out_ch) begin
        res_q_q <= MulResult;
      end
    end else begin
      // Frozen: pulses drop, everything else holds.
      ack_i_q   <= 1'b0;
      ack_q_q   <= 1'b0;
      valid_i_q <= 1'b0;
      valid_q_q <= 1'b0;
    end
  end

  assign AckI     = ack_i_q;
  assign AckQ     = ack_q_q;
  assign MulClkEn = Enable;
  assign MulDataA = data_a_q;
  assign MulDataB = data_b_q;
  assign ResultI  = res_i_q;
  assign ValidI   = valid_i_q;
  assign ResultQ  = res_q_q;
  assign ValidQ   = valid_q_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter with a signed behavioural multiplier attached.
module tb_mult_share_arbiter;
  localparam int W   = 12;
  localparam int LAT = 2;

  logic          Clock = 1'b0;
  logic          Reset, Enable, ReqI, ReqQ;
  logic [W-1:0]  AI, BI, AQ, BQ;
  logic          AckI, AckQ, MulClkEn, ValidI, ValidQ;
  logic [W-1:0]  MulDataA, MulDataB;
  logic [2*W-1:0] MulResult, ResultI, ResultQ;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  mult_share_arbiter #(.WIDTH(W), .LATENCY(LAT)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable),
    .ReqI(ReqI), .AI(AI), .BI(BI), .AckI(AckI),
    .ReqQ(ReqQ), .AQ(AQ), .BQ(BQ), .AckQ(AckQ),
    .MulClkEn(MulClkEn), .MulDataA(MulDataA), .MulDataB(MulDataB),
    .MulResult(MulResult),
    .ResultI(ResultI), .ValidI(ValidI), .ResultQ(ResultQ), .ValidQ(ValidQ)
  );

  function automatic logic [2*W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] x, y;
    x = {{W{a[W-1]}}, a};
    y = {{W{b[W-1]}}, b};
    return x * y;
  endfunction

  // Behavioural multiplier: LAT enabled cycles from operands to result.
  logic [2*W-1:0] mul_p [LAT];
  always_ff @(posedge Clock) begin
    if (MulClkEn) begin
      mul_p[0] <= smul(MulDataA, MulDataB);
      for (int i = 1; i < LAT; i++) mul_p[i] <= mul_p[i-1];
    end
  end
  assign MulResult = mul_p[LAT-1];

  // Reference model: issue/delivery bookkeeping by enabled-cycle number.
  typedef struct {
    int            due;
    bit            ch;
    logic [2*W-1:0] p;
  } pend_t;
  pend_t          pend[$];
  int             en_cnt = 0;
  bit             m_acki = 0, m_ackq = 0, m_vi = 0, m_vq = 0, m_prio_q = 0, m_clken = 0;
  logic [W-1:0]   m_mda = '0, m_mdb = '0;
  logic [2*W-1:0] m_resi = '0, m_resq = '0;
  int             cyc = 0;

  task automatic model_step(input bit rst, input bit en, input bit ri, input logic [W-1:0] ai,
                            input logic [W-1:0] bi, input bit rq, input logic [W-1:0] aq,
                            input logic [W-1:0] bq);
    bit ei, eq, gi, gq;
    m_clken = en;
    if (rst) begin
      m_acki = 0; m_ackq = 0; m_vi = 0; m_vq = 0; m_prio_q = 0;
      m_mda = '0; m_mdb = '0; m_resi = '0; m_resq = '0;
      pend.delete();
    end else if (!en) begin
      m_acki = 0; m_ackq = 0; m_vi = 0; m_vq = 0;
    end else begin
      en_cnt++;
      ei = ri && !m_acki;
      eq = rq && !m_ackq;
      gi = ei && (!eq || !m_prio_q);
      gq = eq && !gi;
      if (ei && eq) m_prio_q = !m_prio_q;
      m_acki = gi;
      m_ackq = gq;
      if (gi) begin
        m_mda = ai; m_mdb = bi;
        pend.push_back('{en_cnt + LAT + 1, 1'b0, smul(ai, bi)});
      end
      if (gq) begin
        m_mda = aq; m_mdb = bq;
        pend.push_back('{en_cnt + LAT + 1, 1'b1, smul(aq, bq)});
      end
      m_vi = 0; m_vq = 0;
      while (pend.size() > 0 && pend[0].due == en_cnt) begin
        if (pend[0].ch) begin m_vq = 1; m_resq = pend[0].p; end
        else begin m_vi = 1; m_resi = pend[0].p; end
        void'(pend.pop_front());
      end
    end
  endtask

  // Advance one clock with the current inputs, then compare against the model.
  task automatic tick();
    bit rst, en, ri, rq;
    logic [W-1:0] ai, bi, aq, bq;
    logic [4*W+4*W+4:0] got, exp;
    rst = Reset; en = Enable; ri = ReqI; rq = ReqQ;
    ai = AI; bi = BI; aq = AQ; bq = BQ;
    @(posedge Clock);
    #1;
    cyc++;
    model_step(rst, en, ri, ai, bi, rq, aq, bq);
    got = {MulClkEn, AckI, AckQ, ValidI, ValidQ, MulDataA, MulDataB, ResultI, ResultQ};
    exp = {m_clken, m_acki, m_ackq, m_vi, m_vq, m_mda, m_mdb, m_resi, m_resq};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model cyc=%0d got clken=%b ack=%b%b vld=%b%b md=%h/%h res=%h/%h exp clken=%b ack=%b%b vld=%b%b md=%h/%h res=%h/%h",
               cyc, MulClkEn, AckI, AckQ, ValidI, ValidQ, MulDataA, MulDataB, ResultI, ResultQ,
               m_clken, m_acki, m_ackq, m_vi, m_vq, m_mda, m_mdb, m_resi, m_resq);
    end
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit en, input bit ri, input logic [W-1:0] ai,
                       input logic [W-1:0] bi, input bit rq, input logic [W-1:0] aq,
                       input logic [W-1:0] bq);
    Reset = rst; Enable = en; ReqI = ri; AI = ai; BI = bi; ReqQ = rq; AQ = aq; BQ = bq;
  endtask

  typedef struct {
    bit             rst, en, ri;
    logic [W-1:0]   ai, bi;
    bit             rq;
    logic [W-1:0]   aq, bq;
    bit             acki, ackq, vi, vq;
    logic [W-1:0]   mda, mdb;
    logic [2*W-1:0] resi, resq;
  } vec_t;

  localparam logic [W-1:0]   M7  = 12'hFF9;     // -7
  localparam logic [2*W-1:0] M42 = 24'hFFFFD6;  // -42

  vec_t vec [21];

  initial begin
    int seen_at, nack, nval;
    bit got_valid;

    // Reset with both requesting, I-first grant, Q follow-up, deliveries.
    vec[0]  = '{1,1, 1,15,3, 1,M7,6,  0,0,0,0, 0,0,   0,0};
    vec[1]  = '{1,1, 1,15,3, 1,M7,6,  0,0,0,0, 0,0,   0,0};
    vec[2]  = '{0,1, 1,15,3, 1,M7,6,  1,0,0,0, 15,3,  0,0};
    vec[3]  = '{0,1, 0,0,0,  1,M7,6,  0,1,0,0, M7,6,  0,0};
    vec[4]  = '{0,1, 0,0,0,  0,0,0,   0,0,0,0, M7,6,  0,0};
    vec[5]  = '{0,1, 0,0,0,  0,0,0,   0,0,1,0, M7,6,  45,0};
    vec[6]  = '{0,1, 0,0,0,  0,0,0,   0,0,0,1, M7,6,  45,M42};
    vec[7]  = '{0,1, 0,0,0,  0,0,0,   0,0,0,0, M7,6,  45,M42};
    // Continuous contention from reset: I,Q,I,Q,I on consecutive edges.
    vec[8]  = '{1,1, 1,25,4, 1,M7,6,  0,0,0,0, 0,0,   0,0};
    vec[9]  = '{0,1, 1,25,4, 1,M7,6,  1,0,0,0, 25,4,  0,0};
    vec[10] = '{0,1, 1,25,4, 1,M7,6,  0,1,0,0, M7,6,  0,0};
    vec[11] = '{0,1, 1,25,4, 1,M7,6,  1,0,0,0, 25,4,  0,0};
    vec[12] = '{0,1, 1,25,4, 1,M7,6,  0,1,1,0, M7,6,  100,0};
    vec[13] = '{0,1, 1,25,4, 1,M7,6,  1,0,0,1, 25,4,  100,M42};
    vec[14] = '{0,1, 0,0,0,  0,0,0,   0,0,1,0, 25,4,  100,M42};
    vec[15] = '{0,1, 0,0,0,  0,0,0,   0,0,0,1, 25,4,  100,M42};
    vec[16] = '{0,1, 0,0,0,  0,0,0,   0,0,1,0, 25,4,  100,M42};
    // Pointer now favours Q (only the first contention toggled it).
    vec[17] = '{0,1, 1,1,1,  1,2,3,   0,1,0,0, 2,3,   100,M42};
    vec[18] = '{0,1, 0,0,0,  0,0,0,   0,0,0,0, 2,3,   100,M42};
    vec[19] = '{0,1, 0,0,0,  0,0,0,   0,0,0,0, 2,3,   100,M42};
    vec[20] = '{0,1, 0,0,0,  0,0,0,   0,0,0,1, 2,3,   100,24'd6};

    for (int n = 0; n < 21; n++) begin
      drive(vec[n].rst, vec[n].en, vec[n].ri, vec[n].ai, vec[n].bi,
            vec[n].rq, vec[n].aq, vec[n].bq);
      tick();
      checks++;
      if ({AckI, AckQ, ValidI, ValidQ, MulDataA, MulDataB, ResultI, ResultQ} !==
          {vec[n].acki, vec[n].ackq, vec[n].vi, vec[n].vq, vec[n].mda, vec[n].mdb,
           vec[n].resi, vec[n].resq}) begin
        errors++;
        $display("FAIL vec%0d got ack=%b%b vld=%b%b md=%h/%h res=%h/%h exp ack=%b%b vld=%b%b md=%h/%h res=%h/%h",
                 n, AckI, AckQ, ValidI, ValidQ, MulDataA, MulDataB, ResultI, ResultQ,
                 vec[n].acki, vec[n].ackq, vec[n].vi, vec[n].vq, vec[n].mda, vec[n].mdb,
                 vec[n].resi, vec[n].resq);
      end
    end

    // Lone streaming: I held, grants every other cycle.
    nack = 0; nval = 0;
    drive(0, 1, 1, 12'd50, 12'd2, 0, 0, 0);
    for (int n = 0; n < 12; n++) begin
      tick();
      nack += int'(AckI);
      nval += int'(ValidI);
    end
    check1("stream_acks", nack, 6);
    check1("stream_valids", nval, 5);
    check1("stream_result", ResultI, 100);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();

    // Enable gap: issue I, freeze two cycles, delivery slips by two.
    drive(0, 1, 1, 12'd15, 12'd3, 0, 0, 0);
    tick();
    check1("gap_issue_ack", AckI, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check1("gap_clken", MulClkEn, 0);
    check1("gap_no_pulse", {AckI, AckQ, ValidI, ValidQ}, 0);
    tick();
    check1("gap_no_pulse2", {AckI, AckQ, ValidI, ValidQ}, 0);
    Enable = 1;
    seen_at = -1;
    for (int n = 3; n < 10; n++) begin
      tick();
      if (ValidI && seen_at < 0) seen_at = n;
    end
    check1("gap_valid_cycle", seen_at, 5);
    check1("gap_result", ResultI, 45);

    // Reset mid-flight: issue I then Q, reset, nothing may be delivered.
    drive(0, 1, 1, 12'd15, 12'd3, 1, 12'd20, 12'd5);
    tick();
    check1("mid_ack_i", AckI, 1);
    ReqI = 0;
    tick();
    check1("mid_ack_q", AckQ, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    Reset = 0;
    got_valid = 0;
    repeat (8) begin
      tick();
      if (ValidI || ValidQ) got_valid = 1;
    end
    check1("mid_no_valid", got_valid, 0);
    drive(0, 1, 1, 12'd1, 12'd2, 1, 12'd3, 12'd4);
    tick();
    check1("mid_prio_i", {AckI, AckQ}, 2'b10);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    repeat (5) tick();

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      Reset  = ($urandom_range(99) < 2);
      Enable = ($urandom_range(99) < 80);
      if (!ReqI || m_acki) begin
        ReqI = ($urandom_range(99) < 60);
        AI = W'($urandom); BI = W'($urandom);
      end
      if (!ReqQ || m_ackq) begin
        ReqQ = ($urandom_range(99) < 60);
        AQ = W'($urandom); BQ = W'($urandom);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
